// File: rtl/uart_autobaud_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_autobaud_ctrl
// Brief    : Start-bit width autobaud; optional confirm via AUTOBAUD_CONFIRM_EN
// Revision : 1.0 - initial release
// ============================================================================
module uart_autobaud_ctrl #(
    parameter int         DIV0      = 434,
    parameter int         DIV1      = 868,
    parameter int         DIV2      = 1302,
    parameter int         DIV3      = 5208,
    parameter logic [7:0] SYNC_CHAR = 8'h55,
    parameter int         CONF_TO   = 131072
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_din,
    input  logic       rx_vld,
    input  logic [7:0] rx_dout,
    input  logic       relock,
    output logic [1:0] baud_sel,
    output logic       locked,
    output logic       lock_fail
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEAS    = 2'd1,
        CONFIRM = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [12:0] C_W_MAX = 13'd8191;
    localparam logic [13:0] C_LO0 = 14'(DIV0 - (DIV0 >> 3));
    localparam logic [13:0] C_HI0 = 14'(DIV0 + (DIV0 >> 3));
    localparam logic [13:0] C_LO1 = 14'(DIV1 - (DIV1 >> 3));
    localparam logic [13:0] C_HI1 = 14'(DIV1 + (DIV1 >> 3));
    localparam logic [13:0] C_LO2 = 14'(DIV2 - (DIV2 >> 3));
    localparam logic [13:0] C_HI2 = 14'(DIV2 + (DIV2 >> 3));
    localparam logic [13:0] C_LO3 = 14'(DIV3 - (DIV3 >> 3));
    localparam logic [13:0] C_HI3 = 14'(DIV3 + (DIV3 >> 3));

    state_t      r_state;
    logic [12:0] r_w;
    logic        r_sync1, r_sync2, r_hist;
    logic        w_fall, w_rise;
    logic        w_match;
    logic [1:0]  w_k;
    logic [13:0] w_wx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= rx_din;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_fall = r_hist & ~r_sync2;
    assign w_rise = ~r_hist & r_sync2;
    assign w_wx   = {1'b0, r_w};

    // Windows are disjoint for sane divisor sets, so first hit wins.
    always_comb begin
        w_match = 1'b1;
        w_k     = 2'd0;
        if (w_wx >= C_LO0 && w_wx <= C_HI0)      w_k = 2'd0;
        else if (w_wx >= C_LO1 && w_wx <= C_HI1) w_k = 2'd1;
        else if (w_wx >= C_LO2 && w_wx <= C_HI2) w_k = 2'd2;
        else if (w_wx >= C_LO3 && w_wx <= C_HI3) w_k = 2'd3;
        else                                     w_match = 1'b0;
    end

`ifdef AUTOBAUD_CONFIRM_EN
    localparam logic [16:0] C_CONF_LAST = 17'(CONF_TO - 1);
    logic [16:0] r_cnt;
    logic        r_guard_done;
    logic [16:0] w_div;
    logic [16:0] w_guard_last;

    always_comb begin
        case (baud_sel)
            2'd0:    w_div = 17'(DIV0);
            2'd1:    w_div = 17'(DIV1);
            2'd2:    w_div = 17'(DIV2);
            default: w_div = 17'(DIV3);
        endcase
        w_guard_last = (w_div << 3) + (w_div << 1) - 17'd1;
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{rx_vld, rx_dout, SYNC_CHAR, CONF_TO[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_w          <= '0;
            baud_sel     <= 2'd0;
            locked       <= 1'b0;
            lock_fail    <= 1'b0;
`ifdef AUTOBAUD_CONFIRM_EN
            r_cnt        <= '0;
            r_guard_done <= 1'b0;
`endif
        end else begin
            lock_fail <= 1'b0;
            if (relock) begin
                r_state      <= IDLE;
                r_w          <= '0;
                locked       <= 1'b0;
`ifdef AUTOBAUD_CONFIRM_EN
                r_cnt        <= '0;
                r_guard_done <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_fall) begin
                            r_state <= MEAS;
                            r_w     <= 13'd1;
                        end
                    end
                    MEAS: begin
                        if (w_rise) begin
                            r_w <= '0;
                            if (w_match) begin
                                baud_sel     <= w_k;
`ifdef AUTOBAUD_CONFIRM_EN
                                r_state      <= CONFIRM;
                                r_cnt        <= '0;
                                r_guard_done <= 1'b0;
`else
                                r_state      <= LOCKED;
                                locked       <= 1'b1;
`endif
                            end else begin
                                lock_fail <= 1'b1;
                                r_state   <= IDLE;
                            end
                        end else if (!r_sync2 && r_w != C_W_MAX) begin
                            r_w <= r_w + 13'd1;
                        end
                    end
`ifdef AUTOBAUD_CONFIRM_EN
                    // Guard spans the measured character, which the receiver
                    // decoded at the stale rate.
                    CONFIRM: begin
                        if (!r_guard_done) begin
                            if (r_cnt == w_guard_last) begin
                                r_cnt        <= '0;
                                r_guard_done <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 17'd1;
                            end
                        end else if (rx_vld) begin
                            r_cnt        <= '0;
                            r_guard_done <= 1'b0;
                            if (rx_dout == SYNC_CHAR) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end else begin
                                lock_fail <= 1'b1;
                                r_state   <= IDLE;
                            end
                        end else if (r_cnt == C_CONF_LAST) begin
                            r_cnt        <= '0;
                            r_guard_done <= 1'b0;
                            lock_fail    <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 17'd1;
                        end
                    end
`endif
                    LOCKED: begin
                        locked <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_autobaud_ctrl
// Brief    : Directed bench with cycle-timed event model for uart_autobaud_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_autobaud_ctrl;

    localparam int TB_CONF_TO = 3000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_din;
    logic       rx_vld;
    logic [7:0] rx_dout;
    logic       relock;
    logic [1:0] baud_sel;
    logic       locked;
    logic       lock_fail;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: scheduled line/receiver events keyed by the clock edge they hit.
    int fall_at[int];
    int relock_at[int];
    int vld_at[int];
    int m_st, m_sel, m_locked, m_fail;
    int res_cyc, res_len;
`ifdef AUTOBAUD_CONFIRM_EN
    int conf_m, conf_g;
`endif

    uart_autobaud_ctrl #(
        .DIV0      (434),
        .DIV1      (868),
        .DIV2      (1302),
        .DIV3      (5208),
        .SYNC_CHAR (8'h55),
        .CONF_TO   (TB_CONF_TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_din    (rx_din),
        .rx_vld    (rx_vld),
        .rx_dout   (rx_dout),
        .relock    (relock),
        .baud_sel  (baud_sel),
        .locked    (locked),
        .lock_fail (lock_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(input int k);
        case (k)
            0:       return 434;
            1:       return 868;
            2:       return 1302;
            default: return 5208;
        endcase
    endfunction

    function automatic int classify(input int len);
        int w;
        int d;
        w = (len > 8191) ? 8191 : len;
        for (int k = 0; k < 4; k++) begin
            d = div_of(k);
            if (w >= d - d / 8 && w <= d + d / 8) return k;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        fall_at.delete();
        relock_at.delete();
        vld_at.delete();
        m_st = 0; m_sel = 0; m_locked = 0; m_fail = 0;
        res_cyc = -1; res_len = 0;
    endfunction

    function automatic void model_step(input int c);
        int k;
        m_fail = 0;
        if (relock_at.exists(c)) begin
            m_st = 0;
            m_locked = 0;
            return;
        end
        if (m_st == 1 && c == res_cyc) begin
            k = classify(res_len);
            if (k < 0) begin
                m_fail = 1;
                m_st = 0;
            end else begin
                m_sel = k;
`ifdef AUTOBAUD_CONFIRM_EN
                m_st = 2;
                conf_m = c;
                conf_g = 10 * div_of(k);
`else
                m_st = 3;
                m_locked = 1;
`endif
            end
        end
`ifdef AUTOBAUD_CONFIRM_EN
        else if (m_st == 2 && c > conf_m + conf_g) begin
            if (vld_at.exists(c)) begin
                if (vld_at[c] == 'h55) begin
                    m_st = 3;
                    m_locked = 1;
                end else begin
                    m_st = 0;
                    m_fail = 1;
                end
            end else if (c == conf_m + conf_g + TB_CONF_TO) begin
                m_st = 0;
                m_fail = 1;
            end
        end
`endif
        else if (m_st == 0 && fall_at.exists(c)) begin
            m_st = 1;
            res_len = fall_at[c];
            res_cyc = c + res_len;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            model_step(cyc);
            check("outputs", {28'd0, baud_sel, locked, lock_fail},
                  {28'd0, m_sel[1:0], m_locked[0], m_fail[0]});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line_low(input int len);
        fall_at[cyc + 3] = len;
        rx_din = 1'b0;
        wait_cyc(len);
        rx_din = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bitlen);
        logic [9:0] fr;
        logic       prev;
        int         n0;
        int         run;
        fr   = {1'b1, b, 1'b0};
        n0   = cyc;
        prev = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!fr[i] && prev) begin
                run = 0;
                for (int j = i; j < 10 && !fr[j]; j++) run++;
                fall_at[n0 + i * bitlen + 3] = run * bitlen;
            end
            prev = fr[i];
        end
        for (int i = 0; i < 10; i++) begin
            rx_din = fr[i];
            wait_cyc(bitlen);
        end
        rx_din = 1'b1;
    endtask

    task automatic give_byte(input logic [7:0] b);
        vld_at[cyc + 1] = int'(b);
        rx_vld  = 1'b1;
        rx_dout = b;
        wait_cyc(1);
        rx_vld  = 1'b0;
    endtask

    task automatic do_relock();
        relock_at[cyc + 1] = 1;
        relock = 1'b1;
        wait_cyc(1);
        relock = 1'b0;
    endtask

    // Called on the cycle baud_sel changed; completes the confirmation.
    task automatic confirm_accept();
`ifdef AUTOBAUD_CONFIRM_EN
        int g;
        g = 10 * div_of(m_sel);
        give_byte(8'hA5);
        wait_cyc(g - 2);
        give_byte(8'h55);
        check("guard_last_vld", 32'(locked), 32'd0);
        give_byte(8'h55);
`endif
    endtask

    task automatic meas_expect(input int len, input int exp_fail, input int exp_sel, input string name);
        line_low(len);
        wait_cyc(3);
        check({name, "_fail"}, 32'(lock_fail), 32'(exp_fail));
        check({name, "_sel"}, 32'(baud_sel), 32'(exp_sel));
        if (exp_fail == 0) begin
            confirm_accept();
            check({name, "_lock"}, 32'(locked), 32'd1);
        end
        wait_cyc(10);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 1'b0; rx_din = 1'b1; rx_vld = 1'b0; rx_dout = 8'h00; relock = 1'b0;
        wait_cyc(4);
        check("rst_sel", 32'(baud_sel), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_fail", 32'(lock_fail), 32'd0);
        rst_n = 1'b1;
        wait_cyc(20);

        // Glitch: exact pulse timing of lock_fail
        line_low(200);
        wait_cyc(2);
        check("glitch_pre", 32'(lock_fail), 32'd0);
        wait_cyc(1);
        check("glitch_fail", 32'(lock_fail), 32'd1);
        wait_cyc(1);
        check("glitch_fail_end", 32'(lock_fail), 32'd0);
        check("glitch_sel", 32'(baud_sel), 32'd0);
        wait_cyc(10);
        meas_expect(434, 0, 0, "after_glitch");
        do_relock();
        check("relock0_locked", 32'(locked), 32'd0);
        wait_cyc(10);

        // 57600: baud_sel exactly 3 cycles after the line returns high
        line_low(868);
        wait_cyc(2);
        check("b57600_pre", 32'(baud_sel), 32'd0);
        wait_cyc(1);
        check("b57600_sel", 32'(baud_sel), 32'd1);
        send_byte(8'h55, 868);
`ifdef AUTOBAUD_CONFIRM_EN
        check("b57600_unconf", 32'(locked), 32'd0);
        give_byte(8'h55);
`endif
        check("b57600_lock", 32'(locked), 32'd1);
        do_relock();
        check("relock1_sel", 32'(baud_sel), 32'd1);
        wait_cyc(10);

        // Window boundaries around DIV0
        meas_expect(379, 1, 1, "w379");
        meas_expect(380, 0, 0, "w380");
        do_relock();
        wait_cyc(10);
        meas_expect(488, 0, 0, "w488");
        do_relock();
        wait_cyc(10);
        meas_expect(489, 1, 0, "w489");

`ifdef AUTOBAUD_CONFIRM_EN
        // Wrong byte after guard, then timeout, then relock beating rx_vld
        line_low(434);
        wait_cyc(3 + 4340);
        give_byte(8'hA5);
        check("wrong_byte_fail", 32'(lock_fail), 32'd1);
        wait_cyc(10);
        line_low(434);
        wait_cyc(3 + 4340 + TB_CONF_TO);
        check("timeout_fail", 32'(lock_fail), 32'd1);
        wait_cyc(10);
        line_low(434);
        wait_cyc(3 + 4340 + 5);
        relock_at[cyc + 1] = 1;
        relock = 1'b1;
        give_byte(8'h55);
        relock = 1'b0;
        check("relock_vs_vld", 32'(locked), 32'd0);
        wait_cyc(10);
        line_low(5208);
        wait_cyc(3);
        check("b9600_sel", 32'(baud_sel), 32'd3);
        do_relock();
`else
        send_byte(8'h55, 5208);
        check("b9600_sel", 32'(baud_sel), 32'd3);
        check("b9600_lock", 32'(locked), 32'd1);
        do_relock();
`endif
        wait_cyc(10);

        meas_expect(1302, 0, 2, "b38400");
        do_relock();
        check("relock2_locked", 32'(locked), 32'd0);
        check("relock2_sel", 32'(baud_sel), 32'd2);
        wait_cyc(10);
        meas_expect(434, 0, 0, "relock_to0");
        do_relock();
        wait_cyc(10);
        meas_expect(868, 0, 1, "pre_reset");
        do_relock();
        wait_cyc(10);

        // Asynchronous reset in the middle of a measurement
        fall_at[cyc + 3] = 100000;
        rx_din = 1'b0;
        wait_cyc(100);
        #2;
        rst_n = 1'b0;
        rx_din = 1'b1;
        model_reset();
        #1;
        check("async_rst_sel", 32'(baud_sel), 32'd0);
        check("async_rst_locked", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cyc(10);
        meas_expect(434, 0, 0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_autobaud_ctrl.md
# uart_autobaud_ctrl

Automatic baud-rate configuration controller for the UART receive path. It watches the raw serial line, measures the low width of the start bit of a host-sent sync character (0x55), and classifies it against the four supported divisors. It then drives the receiver's 2-bit `baud_sel` and optionally confirms the choice by checking the next received byte. It sits beside `uart_rx`, sharing its `rx_din` input and consuming its `rx_dout`/`rx_vld` outputs.

## Interface
- `DIV0`, default 434: clk cycles per bit at 115200 (baud_sel 0)
- `DIV1`, default 868: 57600 (baud_sel 1)
- `DIV2`, default 1302: 38400 (baud_sel 2)
- `DIV3`, default 5208: 9600 (baud_sel 3)
- `SYNC_CHAR`, default 8'h55: confirmation byte
- `CONF_TO`, default 131072: confirmation timeout in clk cycles, counted after the guard period
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx_din`  in  1  raw serial line (asynchronous; idle high)
- `rx_vld`  in  1  byte-valid pulse from receiver
- `rx_dout`  in  8  received byte from receiver
- `relock`  in  1  single-cycle request to discard lock and re-measure
- `baud_sel`  out  2  divisor select to receiver
- `locked`  out  1  high while a rate is locked
- `lock_fail`  out  1  single-cycle pulse on rejected measurement or failed confirmation

## Operation
- `rx_din` passes through a 2-FF synchronizer plus 1 history FF. `fall` = history high and synced low; `rise` is the inverse.
- States: IDLE, MEAS, CONFIRM, LOCKED.
- IDLE: on `fall` → MEAS, with width counter W=1.
- MEAS: W += 1 each cycle the synced line is low. W is 13 bits and saturates at 8191. On `rise`, W is classified:
  - W matches k if `DIVk - (DIVk>>3) <= W <= DIVk + (DIVk>>3)`. The windows are disjoint at the default values.
  - On a match: `baud_sel <= k`, then → CONFIRM (or → LOCKED when the macro is off).
  - No match (including a saturated W): pulse `lock_fail`, → IDLE, `baud_sel` unchanged.
- CONFIRM: a 17-bit counter first counts a guard period of `10*DIVk` cycles (computed as `(DIVk<<3)+(DIVk<<1)`).
  - During the guard period, `rx_vld` is ignored. This discards the measured character, which was mis-received at the old rate.
  - After the guard period, the counter restarts and counts to `CONF_TO`.
  - First `rx_vld` with `rx_dout==SYNC_CHAR` → LOCKED.
  - `rx_vld` with any other byte, or counter reaching `CONF_TO`: pulse `lock_fail`, → IDLE.
- LOCKED: `locked`=1 and `baud_sel` is held. Line activity is ignored.
- `relock` has priority in every state. The next state is IDLE, `locked` goes to 0, all counters clear, and `baud_sel` is retained.
- A `fall` in LOCKED or CONFIRM does not start a measurement.

## Timing
- Reset values: `baud_sel`=0, `locked`=0, `lock_fail`=0, state IDLE, synchronizer FFs all 1.
- Synchronizer latency is 2 cycles. Edges on `rx_din` are seen 3 cycles later, so a clean low pulse of L cycles yields W=L.
- `baud_sel` updates the cycle after `rise` is detected in MEAS.
- `locked` rises the cycle after the accepting `rx_vld`, and falls the cycle after `relock`.
- `lock_fail` is exactly 1 cycle wide and registered.
- `rx_vld` coinciding with the last guard cycle is ignored.
- `rx_vld` coinciding with `relock`: `relock` wins.
- An asynchronous reset mid-measurement aborts to the reset values immediately.

## Configuration
- `AUTOBAUD_CONFIRM_EN` defined: CONFIRM state present, as described above.
- `AUTOBAUD_CONFIRM_EN` undefined: CONFIRM is compiled out. A successful classification goes directly to LOCKED, with `locked` rising the same cycle `baud_sel` updates. `rx_vld`, `rx_dout` and `CONF_TO` are unused.

## Test plan
- Line low for 868 cycles, then 0x55 at 57600 after the guard → `baud_sel`=1 one cycle after the rise; `locked`=1 after the confirming `rx_vld`; no `lock_fail`.
- 0x55 frames at 9600 (5208-cycle bits) → `baud_sel`=3; lock after the second character.
- 200-cycle low glitch → `lock_fail` pulse, `baud_sel` stays 0, state IDLE; a following 434-cycle pulse is measured correctly.
- Boundary widths with DIV0 = 434 → the acceptance window is 380..488, so W=380 and W=488 accept with `baud_sel`=0, while W=379 and W=489 pulse `lock_fail`.
- In CONFIRM at 115200, receiver delivers 0xA5 → `lock_fail` and IDLE. A separate run with no `rx_vld` for `CONF_TO` cycles after the guard → `lock_fail`.
- `relock` while LOCKED at `baud_sel`=2 → `locked`=0 next cycle, `baud_sel` remains 2; line low for 434 cycles re-locks at 0.
